mul_radix4_seq: RTL

Multi-cycle radix-4 multiplier co-processor. It sits directly downstream of the data RAM read ports and upstream of ALU write-back. It takes two WIDTH-bit operands, produces a 2*WIDTH-bit product using one radix-4 digit per cycle, then streams the product to write-back one byte per handshake, LSB first. It replaces the flat combinational mux/adder tree and keeps the existing 4-writes-per-MUL byte pattern.

---
 rtl/mul_radix4_seq_pkg.sv | 29 ++
 rtl/mul_radix4_pp.sv | 22 ++
 rtl/mul_radix4_seq.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mul_radix4_seq_pkg.sv
// rtl/mul_radix4_seq_pkg.sv - shared states, width default and byte-stream sizing for mul_radix4_seq
package mul_radix4_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        EMIT = 2'd2
    } mulState_t;

    localparam int MUL_WIDTH_DEF = 16;

    // Bytes streamed per product.
    function automatic int mulNumBytes(input int width);
        return (2 * width) / 8;
    endfunction

    // Width of the byte index; never narrower than one bit.
    function automatic int mulIdxWidth(input int width);
        int nb;
        nb = (2 * width) / 8;
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

    // Cycles from accepted start to the done pulse, for decode-side timing.
    function automatic int mulCalcCycles(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/mul_radix4_pp.sv
// rtl/mul_radix4_pp.sv - radix-4 digit to partial-product select
module mul_radix4_pp #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] iA,
    input  logic [1:0]       iDigit,
    output logic [WIDTH+1:0] oPp
);

    // Digit 3 needs A + 2A, which is the only case requiring an adder.
    always_comb begin
        oPp = '0;
        case (iDigit)
            2'd0: oPp = '0;
            2'd1: oPp = {2'b00, iA};
            2'd2: oPp = {1'b0, iA, 1'b0};
            2'd3: oPp = {2'b00, iA} + {1'b0, iA, 1'b0};
            default: oPp = '0;
        endcase
    end

endmodule

// File: rtl/mul_radix4_seq.sv
// rtl/mul_radix4_seq.sv - sequential radix-4 multiplier with LSB-first byte streamer (MUL_SIGNED_EN: two's complement operands)
module mul_radix4_seq
    import mul_radix4_seq_pkg::*;
#(
    parameter int  WIDTH  = MUL_WIDTH_DEF,
    localparam int NBYTES = mulNumBytes(WIDTH),
    localparam int IDXW   = mulIdxWidth(WIDTH)
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 iStart,
    input  logic [WIDTH-1:0]     iA,
    input  logic [WIDTH-1:0]     iB,
    output logic                 oBusy,
    output logic                 oDone,
    output logic [2*WIDTH-1:0]   oProduct,
    output logic [7:0]           oByte,
    output logic                 oByteValid,
    input  logic                 iByteReady,
    output logic [IDXW-1:0]      oByteIdx
);

    localparam int              KW       = $clog2(WIDTH / 2 + 1);
    localparam logic [KW-1:0]   KLAST    = KW'(WIDTH / 2);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NBYTES - 1);

    mulState_t            state;
    mulState_t            stateNext;
    logic [WIDTH-1:0]     aReg;
    logic [WIDTH-1:0]     bReg;
    logic [WIDTH-1:0]     aIn;
    logic [WIDTH-1:0]     bIn;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   result;
    logic [KW-1:0]        k;
    logic [WIDTH+1:0]     pp;
    logic                 lastStep;
    logic                 lastByte;
    logic                 xfer;
    logic                 busyNext;
    logic                 doneNext;
    logic                 validNext;
`ifdef MUL_SIGNED_EN
    logic                 signReg;
`endif

    mul_radix4_pp #(.WIDTH(WIDTH)) uPp (
        .iA     (aReg),
        .iDigit (bReg[1:0]),
        .oPp    (pp)
    );

    // k runs 0..WIDTH/2-1 for digits; k == WIDTH/2 is the publish cycle.
    assign lastStep = (k == KLAST);
    assign lastByte = (oByteIdx == IDX_LAST);
    assign xfer     = oByteValid & iByteReady;
    assign addend   = (2*WIDTH)'(pp) << {k, 1'b0};
    assign oByte    = oProduct[8*oByteIdx +: 8];

    // Operand conditioning and final sign fix-up.
    always_comb begin
`ifdef MUL_SIGNED_EN
        aIn    = iA[WIDTH-1] ? -iA : iA;
        bIn    = iB[WIDTH-1] ? -iB : iB;
        result = signReg ? -acc : acc;
`else
        aIn    = iA;
        bIn    = iB;
        result = acc;
`endif
    end

    // State register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (iStart) stateNext = CALC;
            CALC: if (lastStep) stateNext = EMIT;
            EMIT: if (xfer && lastByte) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Next values of the registered status outputs.
    always_comb begin
        busyNext  = (stateNext != IDLE);
        doneNext  = (state == CALC) && lastStep;
        validNext = (stateNext == EMIT);
    end

    // Datapath: operand capture, digit accumulate, product publish, byte index.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
            oByteValid <= 1'b0;
            oProduct   <= '0;
            oByteIdx   <= '0;
            aReg       <= '0;
            bReg       <= '0;
            acc        <= '0;
            k          <= '0;
`ifdef MUL_SIGNED_EN
            signReg    <= 1'b0;
`endif
        end else begin
            oBusy      <= busyNext;
            oDone      <= doneNext;
            oByteValid <= validNext;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        aReg <= aIn;
                        bReg <= bIn;
                        acc  <= '0;
                        k    <= '0;
`ifdef MUL_SIGNED_EN
                        signReg <= iA[WIDTH-1] ^ iB[WIDTH-1];
`endif
                    end
                end
                CALC: begin
                    if (lastStep) begin
                        oProduct <= result;
                        oByteIdx <= '0;
                    end else begin
                        acc  <= acc + addend;
                        bReg <= bReg >> 2;
                        k    <= k + KW'(1);
                    end
                end
                EMIT: begin
                    if (xfer) begin
                        oByteIdx <= lastByte ? '0 : oByteIdx + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
